// File: rtl/rggen_atomic_register.sv
// Multi-word register front end: partial writes are buffered and committed as one
// merged write, wide reads are snapshotted on the first word, plus wait states.
module rggen_atomic_register #(
  parameter bit                  READABLE       = 1'b1,
  parameter bit                  WRITABLE       = 1'b1,
  parameter int unsigned         ADDRESS_WIDTH  = 8,
  parameter int unsigned         OFFSET_ADDRESS = 0,
  parameter int unsigned         BUS_WIDTH      = 32,
  parameter int unsigned         DATA_WIDTH     = BUS_WIDTH,
  parameter bit [DATA_WIDTH-1:0] VALID_BITS     = '1,
  parameter int unsigned         REGISTER_INDEX = 0,
  parameter int unsigned         WRITE_ORDER    = 0,
  parameter int unsigned         WAIT_CYCLES    = 0
)(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_register_valid,
  input  logic [1:0]                 i_register_access,
  input  logic [ADDRESS_WIDTH-1:0]   i_register_address,
  input  logic [BUS_WIDTH-1:0]       i_register_write_data,
  input  logic [BUS_WIDTH/8-1:0]     i_register_strobe,
  output logic                       o_register_active,
  output logic                       o_register_ready,
  output logic [1:0]                 o_register_status,
  output logic [BUS_WIDTH-1:0]       o_register_read_data,
  output logic [DATA_WIDTH-1:0]      o_register_value,
  input  logic                       i_additional_match,
  input  logic                       i_shadow_clear,
  output logic                       o_pending_commit,
  output logic                       o_bit_field_valid,
  output logic [DATA_WIDTH-1:0]      o_bit_field_read_mask,
  output logic [DATA_WIDTH-1:0]      o_bit_field_write_mask,
  output logic [DATA_WIDTH-1:0]      o_bit_field_write_data,
  input  logic [DATA_WIDTH-1:0]      i_bit_field_read_data,
  input  logic [DATA_WIDTH-1:0]      i_bit_field_value
);
  localparam int unsigned WORDS         = DATA_WIDTH / BUS_WIDTH;
  localparam int unsigned BUS_BYTES     = BUS_WIDTH / 8;
  localparam int unsigned START         = OFFSET_ADDRESS + (DATA_WIDTH / 8) * REGISTER_INDEX;
  localparam int unsigned COMMIT_WORD   = (WRITE_ORDER != 0) ? 0 : WORDS - 1;
  localparam int unsigned SNAPSHOT_WORD = (WRITE_ORDER != 0) ? WORDS - 1 : 0;
  localparam int unsigned COUNT_WIDTH   = 8;

  logic                   write;
  logic                   access_ok;
  logic [WORDS-1:0]       word_match;
  logic [COUNT_WIDTH-1:0] count;
  logic [BUS_WIDTH-1:0]   strobe_mask;
  logic [DATA_WIDTH-1:0]  live_data;
  logic [DATA_WIDTH-1:0]  shadow_data;
  logic [DATA_WIDTH-1:0]  shadow_data_next;
  logic [DATA_WIDTH-1:0]  shadow_mask;
  logic [DATA_WIDTH-1:0]  shadow_mask_next;
  logic [DATA_WIDTH-1:0]  snapshot_data;
  logic [DATA_WIDTH-1:0]  snapshot_data_next;
  logic                   snapshot_valid;
  logic                   snapshot_valid_next;
  logic                   unused_access;

  assign write         = i_register_access[0];
  assign unused_access = i_register_access[1];
  assign access_ok     = write ? WRITABLE : READABLE;
  assign live_data     = i_bit_field_read_data & VALID_BITS;

  // Per-word byte-range decode
  for (genvar k = 0; k < WORDS; k++) begin : g_decode
    localparam int unsigned LO = START + BUS_BYTES * k;
    assign word_match[k] = (i_register_address >= ADDRESS_WIDTH'(LO)) &&
                           (i_register_address <= ADDRESS_WIDTH'(LO + BUS_BYTES - 1)) &&
                           access_ok && i_additional_match;
  end

  for (genvar b = 0; b < BUS_BYTES; b++) begin : g_strobe
    assign strobe_mask[8*b +: 8] = {8{i_register_strobe[b]}};
  end

  assign o_register_active = |word_match;
  assign o_register_ready  = !i_rst && i_register_valid && o_register_active &&
                             (count == COUNT_WIDTH'(WAIT_CYCLES));
  assign o_register_status = 2'b00;
  assign o_register_value  = VALID_BITS & i_bit_field_value;
  assign o_pending_commit  = |shadow_mask;

  // Side effects and bit-field strobes only in the ready cycle
  always_comb begin
    o_bit_field_valid      = 1'b0;
    o_bit_field_read_mask  = '0;
    o_bit_field_write_mask = '0;
    o_bit_field_write_data = '0;
    o_register_read_data   = '0;
    shadow_data_next       = i_shadow_clear ? '0 : shadow_data;
    shadow_mask_next       = i_shadow_clear ? '0 : shadow_mask;
    snapshot_data_next     = snapshot_data;
    snapshot_valid_next    = snapshot_valid;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (o_register_ready && word_match[k]) begin
        if (write) begin
          if (k == COMMIT_WORD) begin
            // Commit uses the pre-clear shadow with this word's bytes overlaid
            o_bit_field_valid      = 1'b1;
            o_bit_field_write_mask = shadow_mask;
            o_bit_field_write_mask[k*BUS_WIDTH +: BUS_WIDTH] =
              shadow_mask[k*BUS_WIDTH +: BUS_WIDTH] | strobe_mask;
            o_bit_field_write_data = shadow_data;
            o_bit_field_write_data[k*BUS_WIDTH +: BUS_WIDTH] =
              (shadow_data[k*BUS_WIDTH +: BUS_WIDTH] & ~strobe_mask) |
              (i_register_write_data & strobe_mask);
            shadow_data_next    = '0;
            shadow_mask_next    = '0;
            snapshot_valid_next = 1'b0;
          end else begin
            shadow_data_next[k*BUS_WIDTH +: BUS_WIDTH] =
              (shadow_data_next[k*BUS_WIDTH +: BUS_WIDTH] & ~strobe_mask) |
              (i_register_write_data & strobe_mask);
            shadow_mask_next[k*BUS_WIDTH +: BUS_WIDTH] =
              shadow_mask_next[k*BUS_WIDTH +: BUS_WIDTH] | strobe_mask;
          end
        end else if (k == SNAPSHOT_WORD) begin
          o_bit_field_valid     = 1'b1;
          o_bit_field_read_mask = '1;
          o_register_read_data  = live_data[k*BUS_WIDTH +: BUS_WIDTH];
          snapshot_data_next    = live_data;
          snapshot_valid_next   = 1'b1;
        end else if (snapshot_valid) begin
          o_register_read_data = snapshot_data[k*BUS_WIDTH +: BUS_WIDTH];
        end else begin
          o_bit_field_valid = 1'b1;
          o_bit_field_read_mask[k*BUS_WIDTH +: BUS_WIDTH] = '1;
          o_register_read_data = live_data[k*BUS_WIDTH +: BUS_WIDTH];
        end
      end
    end
  end

  // Wait counter, shadow buffer and snapshot state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count          <= '0;
      shadow_data    <= '0;
      shadow_mask    <= '0;
      snapshot_data  <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      if (i_register_valid && o_register_active && !o_register_ready) begin
        count <= count + COUNT_WIDTH'(1);
      end else begin
        count <= '0;
      end
      shadow_data    <= shadow_data_next;
      shadow_mask    <= shadow_mask_next;
      snapshot_data  <= snapshot_data_next;
      snapshot_valid <= snapshot_valid_next;
    end
  end

endmodule
